fp_mult_sched: RTL
==================

Name: fp_mult_sched

Overview:
- Scheduler that shares one iterative single-precision shift-add multiplier (24 iterations per product) among NREQ requesters.
- Arbitrates round-robin, latches the winner's operands, and issues an active-low load pulse to the multiplier.
- Waits for the multiplier's done flag, then returns result, overflow and underflow to the winning requester with a tag.
- Sits between the Nroot iteration controllers and the shared multiplier.

Parameters:
- NREQ, 4: number of requesters, 2..8.
- DW, 32: IEEE-754 single operand width.
- TIMEOUT, 40: maximum WAIT cycles before the op is aborted.
- GUARD, 2: WAIT cycles during which mul_done is ignored, covering stale done from the previous op.

Ports:
- CLK  in  1  clock
- RST  in  1  asynchronous active-low reset
- req_valid  in  NREQ  per-requester request
- req_a  in  NREQ*DW  operand A, requester i at [i*DW +: DW]
- req_b  in  NREQ*DW  operand B, same packing as req_a
- req_ready  out  NREQ  one-hot, 1-cycle pulse when operands are accepted
- mul_a  out  DW  operand A to multiplier, held from latch register
- mul_b  out  DW  operand B to multiplier, held from latch register
- mul_load_n  out  1  active-low 1-cycle load pulse to multiplier
- mul_result  in  DW  multiplier result
- mul_ovf  in  1  multiplier overflow flag
- mul_unf  in  1  multiplier underflow flag
- mul_done  in  1  multiplier done (its enable output)
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_id  out  3  index of the served requester
- rsp_data  out  DW  product
- rsp_ovf  out  1  overflow flag
- rsp_unf  out  1  underflow flag
- rsp_err  out  1  op aborted by timeout
- busy  out  1  state is not IDLE

Behaviour:
- Reset values:
  - State IDLE.
  - req_ready = 0, rsp_valid = 0, rsp_* = 0, mul_a = mul_b = 0, mul_load_n = 1, busy = 0.
  - wait counter = 0; last_grant = NREQ-1, so requester 0 has first priority.
- States:
  - IDLE: if any req_valid, grant g = first set bit searching from last_grant+1 with wrap-around. Latch req_a/req_b[g] into mul_a/mul_b, pulse req_ready[g], store g, go LOAD. With no request, stay in IDLE.
  - LOAD: mul_load_n = 0 for exactly this cycle; clear wait counter; go WAIT.
  - WAIT: counter increments every cycle.
    - mul_done is sampled only when counter >= GUARD.
    - mul_done = 1 (sampled): capture mul_result, mul_ovf, mul_unf into rsp_*; set rsp_err = 0; go RESP.
    - Counter = TIMEOUT with no done: rsp_data = 0, ovf = unf = 0, rsp_err = 1; go RESP.
    - Done and timeout in the same cycle: done wins, rsp_err = 0.
  - RESP: rsp_valid = 1, all rsp_* stable until rsp_ready = 1 is sampled. On acceptance, rsp_valid drops the next cycle, last_grant = stored g, go IDLE.
- Latency:
  - Acceptance to load pulse: 1 cycle.
  - rsp_valid rises the cycle after mul_done is sampled.
  - Scheduler overhead: 3 cycles plus multiplier time.
- Fairness: one op per grant; a requester waiting behind NREQ-1 others is served within NREQ ops.
- Request-line rules:
  - req_valid may drop before grant; it is ignored unless it is high in an IDLE cycle.
  - Requests arriving outside IDLE are held off; req_ready stays 0.
- mul_a and mul_b stay constant from LOAD through RESP. The multiplier loads its operands during its own reset, so they must be stable on the load edge.
- Reset mid-operation: immediate return to reset values. Any in-flight op is dropped with no response, and the next grant starts at requester 0.
- rsp_id is zero-extended to 3 bits.

Decomposition:
- Package fp_sched_pkg:
  - state enum {IDLE, LOAD, WAIT, RESP}.
  - ID_W = 3.
  - Default TIMEOUT and GUARD constants.
- Sub-module rr_arbiter (NREQ): combinational round-robin pick.
  - Inputs: req vector, last_grant.
  - Outputs: one-hot grant, grant index, any.
- All sequencing stays in fp_mult_sched.

Test Plan:
- Single request: requester 1 sends A = 0x3FC00000, B = 0x40000000; multiplier model asserts done 25 cycles after load -> req_ready = 0b0010 for one cycle, one mul_load_n low pulse, rsp_valid with rsp_id = 1, rsp_data = 0x40400000, ovf = unf = err = 0.
- Round-robin: all 4 req_valid held high for 5 ops -> grant order 0, 1, 2, 3, 0; each rsp_id matches its grant.
- Backpressure: rsp_ready held low 10 cycles in RESP -> rsp_valid and rsp_data stable for all 10 cycles, no new req_ready, busy = 1; rsp_ready = 1 -> IDLE the next cycle.
- Stale done guard: mul_done held high at LOAD and low in WAIT cycle 2, later high at WAIT count 26 -> response is taken at count 26, not during guard cycles 0-1.
- Timeout: mul_done stuck at 0 -> rsp_valid after WAIT count 40 with rsp_err = 1, rsp_data = 0.
- Reset mid-op: RST low during WAIT of a requester-2 op -> all outputs return to reset values, no response; after release with requests 0 and 2 pending, requester 0 is granted first.

Source files
------------

// File: rtl/fp_sched_pkg.sv
// Shared types and defaults for the multiplier scheduler.
// State encoding, tag width and wait-window constants.
package fp_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT,
    RESP
  } state_t;

  localparam int ID_W        = 3;
  localparam int TIMEOUT_DEF = 40;
  localparam int GUARD_DEF   = 2;

endpackage

// File: rtl/fp_mult_sched_rr_arbiter.sv
// Combinational round-robin pick.
// Searches upward from last+1 with wrap-around.
module rr_arbiter
  import fp_sched_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] last,
  output logic [NREQ-1:0] gnt,
  output logic [ID_W-1:0] idx,
  output logic            any
);

  localparam int IW = $clog2(NREQ);

  int   j;
  logic found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 1; k <= NREQ; k++) begin
      j = int'(last) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!found && req[j[IW-1:0]]) begin
        gnt[j[IW-1:0]] = 1'b1;
        idx            = ID_W'(j);
        found          = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/fp_mult_sched.sv
// Shares one iterative multiplier among NREQ requesters.
// Round-robin grant, load pulse, guarded wait, tagged response.
module fp_mult_sched
  import fp_sched_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int DW      = 32,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int GUARD   = GUARD_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [NREQ-1:0]  req_valid,
  input  logic [NREQ*DW-1:0] req_a,
  input  logic [NREQ*DW-1:0] req_b,
  output logic [NREQ-1:0]  req_ready,
  output logic [DW-1:0]    mul_a,
  output logic [DW-1:0]    mul_b,
  output logic             mul_load_n,
  input  logic [DW-1:0]    mul_result,
  input  logic             mul_ovf,
  input  logic             mul_unf,
  input  logic             mul_done,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [ID_W-1:0]  rsp_id,
  output logic [DW-1:0]    rsp_data,
  output logic             rsp_ovf,
  output logic             rsp_unf,
  output logic             rsp_err,
  output logic             busy
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t          state_q, state_d;
  logic [ID_W-1:0] gid_q, gid_d;
  logic [ID_W-1:0] last_q, last_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   a_q, a_d, b_q, b_d;
  logic [NREQ-1:0] rdy_q, rdy_d;
  logic            load_n_q, load_n_d;
  logic            rv_q, rv_d;
  logic [DW-1:0]   data_q, data_d;
  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;
  logic            err_q, err_d;

  logic [NREQ-1:0] gnt;
  logic [ID_W-1:0] gidx;
  logic            any;
  logic [DW-1:0]   a_arr [NREQ];
  logic [DW-1:0]   b_arr [NREQ];
  logic [DW-1:0]   a_sel, b_sel;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req  (req_valid),
    .last (last_q),
    .gnt  (gnt),
    .idx  (gidx),
    .any  (any)
  );

  for (genvar i = 0; i < NREQ; i++) begin : g_unp
    assign a_arr[i] = req_a[i*DW +: DW];
    assign b_arr[i] = req_b[i*DW +: DW];
  end

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        a_sel = a_arr[i];
        b_sel = b_arr[i];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    gid_d    = gid_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    rdy_d    = '0;
    load_n_d = 1'b1;
    rv_d     = rv_q;
    data_d   = data_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    err_d    = err_q;
    unique case (state_q)
      IDLE: begin
        if (any) begin
          a_d      = a_sel;
          b_d      = b_sel;
          rdy_d    = gnt;
          gid_d    = gidx;
          load_n_d = 1'b0;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // done wins over a simultaneous timeout
        if (cnt_q >= CW'(GUARD) && mul_done) begin
          data_d  = mul_result;
          ovf_d   = mul_ovf;
          unf_d   = mul_unf;
          err_d   = 1'b0;
          rv_d    = 1'b1;
          state_d = RESP;
        end else if (cnt_q == CW'(TIMEOUT)) begin
          data_d  = '0;
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
          err_d   = 1'b1;
          rv_d    = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rv_d    = 1'b0;
          last_d  = gid_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= IDLE;
      gid_q    <= '0;
      last_q   <= ID_W'(NREQ - 1);
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      rdy_q    <= '0;
      load_n_q <= 1'b1;
      rv_q     <= 1'b0;
      data_q   <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      gid_q    <= gid_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      rdy_q    <= rdy_d;
      load_n_q <= load_n_d;
      rv_q     <= rv_d;
      data_q   <= data_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      err_q    <= err_d;
    end
  end

  assign req_ready  = rdy_q;
  assign mul_a      = a_q;
  assign mul_b      = b_q;
  assign mul_load_n = load_n_q;
  assign rsp_valid  = rv_q;
  assign rsp_id     = gid_q;
  assign rsp_data   = data_q;
  assign rsp_ovf    = ovf_q;
  assign rsp_unf    = unf_q;
  assign rsp_err    = err_q;
  assign busy       = (state_q != IDLE);

endmodule
